// File: rtl/div_pkg.sv
// div_pkg: shared constants and word types for the pulse-swallow divider
package div_pkg;

    localparam int P_MIN       = 2;
    localparam int DEF_WIDTH   = 6;
    localparam int DEF_S_WIDTH = 3;

    typedef logic [DEF_WIDTH-1:0]   p_word_t;
    typedef logic [DEF_S_WIDTH-1:0] s_word_t;

endpackage

// File: rtl/duty_gen.sv
// duty_gen: near-50% Fout from a registered compare of the P down-counter
module duty_gen
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] p_lat,
    output logic             fout
);

    // high from the load cycle until the counter falls to half the period
    always_ff @(posedge clk)
        fout <= rst ? 1'b0 : (load | (cnt > (p_lat >> 1)));

endmodule

// File: rtl/p_counter.sv
// p_counter: program counter of a pulse-swallow divider; P_COUNTER_DUTY50_EN selects near-50% Fout
module p_counter
    import div_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int S_WIDTH = DEF_S_WIDTH
) (
    input  logic               Fin,
    input  logic               rst,
    input  logic [WIDTH-1:0]   Pi,
    input  logic [S_WIDTH-1:0] Si,
    output logic               LDo,
    output logic [S_WIDTH-1:0] So,
    output logic               Fout,
    output logic               cfg_err
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] p_eff;
    logic             load;

    assign load  = (cnt == '0);
    assign p_eff = (Pi < WIDTH'(P_MIN)) ? WIDTH'(P_MIN) : Pi;

    // count down; at terminal count reload from the sampled words and pulse LDo
    always_ff @(posedge Fin) begin
        if (rst) begin
            cnt     <= '0;
            LDo     <= 1'b0;
            So      <= '0;
            cfg_err <= 1'b0;
        end else if (load) begin
            cnt     <= p_eff - 1'b1;
            LDo     <= 1'b1;
            So      <= Si;
            cfg_err <= cfg_err | (Pi < WIDTH'(P_MIN)) | (int'(Si) >= int'(p_eff));
        end else begin
            cnt     <= cnt - 1'b1;
            LDo     <= 1'b0;
        end
    end

`ifdef P_COUNTER_DUTY50_EN
    logic [WIDTH-1:0] p_lat;

    // hold the running period's P so the duty threshold never changes mid-period
    always_ff @(posedge Fin)
        p_lat <= rst ? WIDTH'(P_MIN) : (load ? p_eff : p_lat);

    duty_gen #(.WIDTH(WIDTH)) u_duty (
        .clk   (Fin),
        .rst   (rst),
        .load  (load),
        .cnt   (cnt),
        .p_lat (p_lat),
        .fout  (Fout)
    );
`else
    assign Fout = LDo;
`endif

endmodule

// File: tb/tb_p_counter.sv
// tb_p_counter: directed self-checking bench for p_counter
module tb_p_counter;
    import div_pkg::*;

    logic    Fin = 1'b0;
    logic    rst = 1'b1;
    p_word_t Pi  = '0;
    s_word_t Si  = '0;
    logic    LDo;
    s_word_t So;
    logic    Fout;
    logic    cfg_err;

    int vectors = 0;
    int miscompares = 0;

    p_counter dut (
        .Fin     (Fin),
        .rst     (rst),
        .Pi      (Pi),
        .Si      (Si),
        .LDo     (LDo),
        .So      (So),
        .Fout    (Fout),
        .cfg_err (cfg_err)
    );

    always #5 Fin = ~Fin;

    task automatic tick();
        @(posedge Fin);
        #1;
    endtask

    task automatic do_reset(input int p, input int s);
        rst = 1'b1;
        Pi  = p_word_t'(p);
        Si  = s_word_t'(s);
        tick();
        rst = 1'b0;
    endtask

    function automatic logic exp_fout(input int k, input int p);
`ifdef P_COUNTER_DUTY50_EN
        return k < (p + 1) / 2;
`else
        return k == 0;
`endif
    endfunction

    task automatic test_reset();
        logic [5:0] obs;
        rst = 1'b1;
        Pi  = 6'd5;
        Si  = 3'd2;
        for (int e = 0; e < 3; e++) begin
            tick();
            obs = {LDo, Fout, cfg_err, So};
            vectors++;
            if (obs !== 6'b0) begin
                miscompares++;
                $display("FAIL reset e=%0d: {LDo,Fout,err,So}=%b expected %b", e, obs, 6'b0);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_steady();
        logic [5:0] obs, exp;
        int k;
        for (int e = 1; e <= 15; e++) begin
            tick();
            k   = (e - 1) % 5;
            exp = {k == 0, exp_fout(k, 5), 1'b0, 3'd2};
            obs = {LDo, Fout, cfg_err, So};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL steady e=%0d: {LDo,Fout,err,So}=%b expected %b", e, obs, exp);
            end
        end
    endtask

    task automatic test_ratio_change();
        logic [5:0] obs, exp;
        int k, p;
        do_reset(5, 2);
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e < 6) begin k = e - 1; p = 5; end
            else if (e < 15) begin k = e - 6; p = 9; end
            else begin k = e - 15; p = 9; end
            exp = {k == 0, exp_fout(k, p), 1'b0, (e < 6) ? 3'd2 : 3'd5};
            obs = {LDo, Fout, cfg_err, So};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL ratio_change e=%0d: {LDo,Fout,err,So}=%b expected %b", e, obs, exp);
            end
            if (e == 3) begin
                Pi = 6'd9;
                Si = 3'd5;
            end
        end
    endtask

    task automatic test_clamp_error();
        logic [5:0] obs, exp;
        int k, p;
        do_reset(1, 0);
        for (int e = 1; e <= 13; e++) begin
            tick();
            if (e <= 6) begin k = (e - 1) % 2; p = 2; end
            else begin k = (e - 7) % 6; p = 6; end
            exp = {k == 0, exp_fout(k, p), 1'b1, 3'd0};
            obs = {LDo, Fout, cfg_err, So};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL clamp_error e=%0d: {LDo,Fout,err,So}=%b expected %b", e, obs, exp);
            end
            if (e == 6) Pi = 6'd6;
        end
    endtask

    task automatic test_illegal_swallow();
        logic [5:0] obs, exp;
        int k;
        do_reset(4, 4);
        for (int e = 1; e <= 9; e++) begin
            tick();
            k   = (e - 1) % 4;
            exp = {k == 0, exp_fout(k, 4), 1'b1, 3'd4};
            obs = {LDo, Fout, cfg_err, So};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL illegal_swallow e=%0d: {LDo,Fout,err,So}=%b expected %b", e, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] obs, exp;
        int k;
        do_reset(7, 7);
        for (int e = 1; e <= 13; e++) begin
            tick();
            k = (e < 5) ? e - 1 : (e - 6) % 7;
            if (e < 5) exp = {k == 0, exp_fout(k, 7), 1'b1, 3'd7};
            else if (e == 5) exp = 6'b0;
            else exp = {k == 0, exp_fout(k, 7), 1'b0, 3'd3};
            obs = {LDo, Fout, cfg_err, So};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL reset_mid e=%0d: {LDo,Fout,err,So}=%b expected %b", e, obs, exp);
            end
            if (e == 4) begin
                rst = 1'b1;
                Si  = 3'd3;
            end
            if (e == 5) rst = 1'b0;
        end
    endtask

    task automatic test_rst_vs_tc();
        logic [5:0] obs, exp;
        int k;
        do_reset(3, 1);
        for (int e = 1; e <= 7; e++) begin
            tick();
            k = (e < 4) ? e - 1 : e - 5;
            exp = (e == 4) ? 6'b0 : {k == 0, exp_fout(k, 3), 1'b0, 3'd1};
            obs = {LDo, Fout, cfg_err, So};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL rst_vs_tc e=%0d: {LDo,Fout,err,So}=%b expected %b", e, obs, exp);
            end
            rst = (e == 3);
        end
    endtask

    task automatic test_max_p();
        logic [5:0] obs, exp;
        int k;
        do_reset(63, 7);
        for (int e = 1; e <= 65; e++) begin
            tick();
            k   = (e - 1) % 63;
            exp = {k == 0, exp_fout(k, 63), 1'b0, 3'd7};
            obs = {LDo, Fout, cfg_err, So};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL max_p e=%0d: {LDo,Fout,err,So}=%b expected %b", e, obs, exp);
            end
        end
    endtask

    task automatic test_fout(input int p);
        logic [1:0] obs, exp;
        int k;
        do_reset(p, 1);
        for (int e = 1; e <= 2 * p + 1; e++) begin
            tick();
            k   = (e - 1) % p;
            exp = {k == 0, exp_fout(k, p)};
            obs = {LDo, Fout};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL fout_p%0d e=%0d: {LDo,Fout}=%b expected %b", p, e, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_ratio_change();
        test_clamp_error();
        test_illegal_swallow();
        test_reset_mid();
        test_rst_vs_tc();
        test_max_p();
        test_fout(6);
        test_fout(7);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
